// File: rtl/fphub_add_arbiter.sv
// Round-robin front end that time-shares one combinational FPHUB adder among N requesters.
// Optional macro FPHUB_ARB_SUB_EN enables req_sub (flip Y sign bit at acceptance).
module fphub_add_arbiter #(
  parameter int M       = 24,
  parameter int E       = 8,
  parameter int N       = 2,
  parameter int ADD_LAT = 2,
  localparam int W      = E + M + 1,
  localparam int IW     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*W-1:0]  req_x,
  input  logic [N*W-1:0]  req_y,
  input  logic [N-1:0]    req_sub,
  output logic [W-1:0]    add_x,
  output logic [W-1:0]    add_y,
  input  logic [W-1:0]    add_z,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [W-1:0]    resp_z,
  output logic [IW-1:0]   resp_id,
  output logic            busy
);

`ifdef FPHUB_ARB_SUB_EN
  localparam logic SUB_EN = 1'b1;
`else
  localparam logic SUB_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] last_q, last_d, id_q, id_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [W-1:0]  opx_q, opx_d, opy_q, opy_d, z_q, z_d;
  logic          vld_q, vld_d, busy_q, busy_d;

  logic [IW-1:0] g, cand;
  logic          found, sub_bit;
  logic [W-1:0]  sel_x, sel_y, y_eff;

  // Search from last_grant+1, wrapping mod N so indices >= N never appear.
  always_comb begin
    g     = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_q) + k) % N);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        g     = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && found) req_ready[g] = 1'b1;
  end

  assign sel_x   = req_x[int'(g)*W +: W];
  assign sel_y   = req_y[int'(g)*W +: W];
  assign sub_bit = SUB_EN & req_sub[g];
  assign y_eff   = sel_y ^ {sub_bit, {(W-1){1'b0}}};

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    opx_d   = opx_q;
    opy_d   = opy_q;
    z_d     = z_q;
    case (state_q)
      IDLE: if (found) begin
        opx_d   = sel_x;
        opy_d   = y_eff;
        last_d  = g;
        id_d    = g;
        cnt_d   = 4'(ADD_LAT - 1);
        state_d = EXEC;
      end
      EXEC: if (cnt_q == 4'd0) begin
        z_d     = add_z;
        state_d = RESP;
      end else begin
        cnt_d   = cnt_q - 4'd1;
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    vld_d  = (state_d == RESP);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IW'(N - 1);
      id_q    <= '0;
      cnt_q   <= '0;
      opx_q   <= '0;
      opy_q   <= '0;
      z_q     <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      opx_q   <= opx_d;
      opy_q   <= opy_d;
      z_q     <= z_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  assign add_x      = opx_q;
  assign add_y      = opy_q;
  assign resp_z     = z_q;
  assign resp_id    = id_q;
  assign resp_valid = vld_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fphub_add_arbiter.sv
// Directed bench for fphub_add_arbiter at default parameters (W=33, N=2, ADD_LAT=2).
module tb_fphub_add_arbiter;
  localparam int N = 2;
  localparam int W = 33;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, req_sub;
  logic [N*W-1:0] req_x, req_y;
  logic [W-1:0]   add_x, add_y, add_z, resp_z;
  logic           resp_valid, resp_ready, busy;
  logic [0:0]     resp_id;

  int total = 0;
  int bad   = 0;

  fphub_add_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_sub(req_sub), .add_x(add_x), .add_y(add_y),
    .add_z(add_z), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_z(resp_z), .resp_id(resp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  localparam logic [W-1:0] X0 = 33'h080000000;
  localparam logic [W-1:0] Y0 = 33'h07F000000;
  localparam logic [W-1:0] X1 = 33'h040000000;
  localparam logic [W-1:0] Y1 = 33'h081000000;
  localparam logic [W-1:0] Z0 = 33'h123456789;
`ifdef FPHUB_ARB_SUB_EN
  localparam logic [W-1:0] Y1_EXP = 33'h181000000;
`else
  localparam logic [W-1:0] Y1_EXP = 33'h081000000;
`endif

  initial begin
    logic [N-1:0] exp_rdy;
    rst_n = 1'b0; req_valid = 2'b01; req_sub = 2'b10; resp_ready = 1'b0;
    req_x = {X1, X0}; req_y = {Y1, Y0}; add_z = Z0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_z", 64'(resp_z), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_add_x", 64'(add_x), 64'd0);
    chk("rst_add_y", 64'(add_y), 64'd0);

    // single request: accept cycle 0, resp_valid at cycle 3
    @(negedge clk); rst_n = 1'b1; req_valid = 2'b01; #1;
    chk("c0_req_ready", 64'(req_ready), 64'h1);
    @(negedge clk); req_valid = 2'b00; #1;
    chk("c1_busy", 64'(busy), 64'd1);
    chk("c1_add_x", 64'(add_x), 64'(X0));
    chk("c1_add_y", 64'(add_y), 64'(Y0));
    chk("c1_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk); #1;
    chk("c2_resp_valid", 64'(resp_valid), 64'd0);
    chk("c2_add_x_hold", 64'(add_x), 64'(X0));
    @(negedge clk); #1;
    chk("c3_resp_valid", 64'(resp_valid), 64'd1);
    chk("c3_resp_z", 64'(resp_z), 64'(Z0));
    chk("c3_resp_id", 64'(resp_id), 64'd0);

    // backpressure: stalled in RESP while add_z and req_valid move
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); req_valid = 2'b11; add_z = 33'(i * 7 + 1); #1;
      chk("bp_resp_valid", 64'(resp_valid), 64'd1);
      chk("bp_resp_z", 64'(resp_z), 64'(Z0));
      chk("bp_resp_id", 64'(resp_id), 64'd0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(negedge clk); resp_ready = 1'b1; #1;
    chk("bp_rel_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk); #1;
    chk("bp_next_grant", 64'(req_ready), 64'h2);
    // reset one cycle after acceptance of requester 1
    @(negedge clk); rst_n = 1'b0; #1;
    chk("mid_busy", 64'(busy), 64'd1 - 64'd1);
    chk("mid_add_x", 64'(add_x), 64'd0);
    chk("mid_add_y", 64'(add_y), 64'd0);
    chk("mid_resp_valid", 64'(resp_valid), 64'd0);
    chk("mid_resp_z", 64'(resp_z), 64'd0);
    chk("mid_req_ready", 64'(req_ready), 64'd0);

    // contention: grants 0,1,0,1 every 4 cycles
    @(negedge clk); rst_n = 1'b1; req_valid = 2'b11; resp_ready = 1'b1; add_z = Z0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_rdy = (c % 4 != 0) ? 2'b00 : (((c / 4) % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("cont_req_ready_c%0d", c), 64'(req_ready), 64'(exp_rdy));
      if (c % 4 == 3) begin
        chk("cont_resp_valid", 64'(resp_valid), 64'd1);
        chk("cont_resp_id", 64'(resp_id), 64'((c / 4) % 2));
      end
      if (c == 1) chk("cont_add_y0", 64'(add_y), 64'(Y0));
      if (c == 5) begin
        chk("sub_add_x1", 64'(add_x), 64'(X1));
        chk("sub_add_y1", 64'(add_y), 64'(Y1_EXP));
      end
    end
    req_valid = 2'b00;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
